// File: rtl/gray_float_to_pixel.sv
// gray_float_to_pixel
//
// Return path of the edge-detection stream. Each accepted beat carries one
// IEEE-754 single-precision gray/edge value. It is truncated toward zero to an
// 8-bit unsigned value and packed as {footer, gray, gray, gray}. The footer
// byte is rebuilt from the per-pixel frame flags. A small frame tracker checks
// the framing and reports the pixel count of each completed frame.
//
// Build option: define GRAY_ABS_MAGNITUDE_EN to convert negative finite values
// as |x|, with -inf giving 255. This suits signed gradient outputs. Without the
// macro every negative value clamps to 0. NaN always gives 0.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_data_valid          input beat valid
//   ou_data_ready          input beat can be accepted (global pipeline enable)
//   in_float_pixel         IEEE-754 single gray value
//   in_first_frame         beat is the first pixel of a frame
//   in_pre_last            beat is the next-to-last pixel of a frame
//   in_last_frame          beat is the last pixel of a frame
//   ou_result_valid        output word valid
//   in_result_ready        downstream accepts the output word
//   ou_rgb_pixel           {footer[31:24], gray[23:16], gray[15:8], gray[7:0]}
//   ou_frame_error         sticky framing error, cleared only by rst
//   ou_frame_pixel_count   pixel count of the last completed frame

module gray_float_to_pixel #(
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_data_valid,
    output logic               ou_data_ready,
    input  logic [31:0]        in_float_pixel,
    input  logic               in_first_frame,
    input  logic               in_pre_last,
    input  logic               in_last_frame,
    output logic               ou_result_valid,
    input  logic               in_result_ready,
    output logic [31:0]        ou_rgb_pixel,
    output logic               ou_frame_error,
    output logic [COUNT_W-1:0] ou_frame_pixel_count
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic               en;
    logic               accept;

    logic               vld_p1;
    logic               sign_p1;
    logic [7:0]         exp_p1;
    logic [22:0]        man_p1;
    logic               first_p1;
    logic               pre_last_p1;
    logic               last_p1;

    logic [7:0]         gray_p1;
    logic [7:0]         footer_p1;

    logic [0:0]         state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_inc;
    logic               prev_pre_last;

    // Truncating float -> 8-bit conversion with clamping and saturation.
    function automatic logic [7:0] to_gray(input logic s, input logic [7:0] e,
                                           input logic [22:0] m);
        logic [7:0]  res;
        logic [23:0] sig;
        logic        neg_clamp;
        logic [4:0]  sh;
`ifdef GRAY_ABS_MAGNITUDE_EN
        neg_clamp = 1'b0;
`else
        neg_clamp = s;
`endif
        res = 8'd0;
        sig = 24'd0;
        sh  = 5'd0;
        if (e == 8'd0) begin
            res = 8'd0;
        end else if (e == 8'hFF) begin
            res = (m != 23'd0 || neg_clamp) ? 8'd0 : 8'hFF;
        end else if (neg_clamp) begin
            res = 8'd0;
        end else if (e < 8'd127) begin
            res = 8'd0;
        end else if (e >= 8'd135) begin
            res = 8'hFF;
        end else begin
            // e is 127..134 here, so the shift is 23..16 and the integer
            // part of the significand always fits in 8 bits.
            sh  = 5'(8'd150 - e);
            sig = {1'b1, m} >> sh;
            res = sig[7:0];
        end
        return res;
    endfunction

    // Footer priority: last > pre_last > first.
    function automatic logic [7:0] to_footer(input logic first, input logic pre_last,
                                             input logic last);
        logic [7:0] res;
        if (last)          res = 8'd3;
        else if (pre_last) res = 8'd2;
        else if (first)    res = 8'd1;
        else               res = 8'd0;
        return res;
    endfunction

    // A full output stage that downstream is not taking freezes the pipeline.
    assign en            = !ou_result_valid || in_result_ready;
    assign ou_data_ready = en;
    assign accept        = in_data_valid && en;

    // ---- stage 1: decode ----
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1     <= in_float_pixel[31];
            exp_p1      <= in_float_pixel[30:23];
            man_p1      <= in_float_pixel[22:0];
            first_p1    <= in_first_frame;
            pre_last_p1 <= in_pre_last;
            last_p1     <= in_last_frame;
        end
    end

    assign gray_p1   = to_gray(sign_p1, exp_p1, man_p1);
    assign footer_p1 = to_footer(first_p1, pre_last_p1, last_p1);

    // ---- stage 2: convert and pack ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1          <= 1'b0;
            ou_result_valid <= 1'b0;
            ou_rgb_pixel    <= 32'd0;
        end else if (en) begin
            vld_p1          <= in_data_valid;
            ou_result_valid <= vld_p1;
            ou_rgb_pixel    <= {footer_p1, gray_p1, gray_p1, gray_p1};
        end
    end

    assign count_inc = (count == {COUNT_W{1'b1}}) ? count : count + COUNT_W'(1);

    // Frame tracker, advanced on every accepted input beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            count                <= '0;
            prev_pre_last        <= 1'b0;
            ou_frame_error       <= 1'b0;
            ou_frame_pixel_count <= '0;
        end else if (accept) begin
            prev_pre_last <= in_pre_last;
            if (in_first_frame) begin
                // A first beat inside an open frame abandons that frame.
                if (state == ACTIVE) ou_frame_error <= 1'b1;
                if (in_last_frame) begin
                    ou_frame_pixel_count <= COUNT_W'(1);
                    state                <= IDLE;
                end else begin
                    count <= COUNT_W'(1);
                    state <= ACTIVE;
                end
            end else if (state == IDLE) begin
                ou_frame_error <= 1'b1;
            end else if (in_last_frame) begin
                ou_frame_pixel_count <= count_inc;
                state                <= IDLE;
                if (!prev_pre_last) ou_frame_error <= 1'b1;
            end else begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_gray_float_to_pixel.sv
module tb_gray_float_to_pixel;

    localparam int COUNT_W = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_data_valid = 1'b0;
    logic               ou_data_ready;
    logic [31:0]        in_float_pixel = 32'd0;
    logic               in_first_frame = 1'b0;
    logic               in_pre_last = 1'b0;
    logic               in_last_frame = 1'b0;
    logic               ou_result_valid;
    logic               in_result_ready = 1'b1;
    logic [31:0]        ou_rgb_pixel;
    logic               ou_frame_error;
    logic [COUNT_W-1:0] ou_frame_pixel_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] f;
        logic        first;
        logic        pre;
        logic        last;
    } beat_t;

    beat_t       in_q[$];
    logic [31:0] exp_q[$];

    gray_float_to_pixel #(.COUNT_W(COUNT_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_data_valid        (in_data_valid),
        .ou_data_ready        (ou_data_ready),
        .in_float_pixel       (in_float_pixel),
        .in_first_frame       (in_first_frame),
        .in_pre_last          (in_pre_last),
        .in_last_frame        (in_last_frame),
        .ou_result_valid      (ou_result_valid),
        .in_result_ready      (in_result_ready),
        .ou_rgb_pixel         (ou_rgb_pixel),
        .ou_frame_error       (ou_frame_error),
        .ou_frame_pixel_count (ou_frame_pixel_count)
    );

    always #5 clk = ~clk;

    // Reference conversion: evaluate the real number and truncate.
    function automatic logic [7:0] ref_gray(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 23'd0) return 8'd0;
`ifdef GRAY_ABS_MAGNITUDE_EN
            return 8'd255;
`else
            return f[31] ? 8'd0 : 8'd255;
`endif
        end
        if (e == 0) return 8'd0;
`ifndef GRAY_ABS_MAGNITUDE_EN
        if (f[31]) return 8'd0;
`endif
        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (v >= 255.0) return 8'd255;
        return 8'($rtoi(v));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] f, input logic first,
                                             input logic pre, input logic last);
        logic [7:0] g;
        logic [7:0] ft;
        g  = ref_gray(f);
        ft = last ? 8'd3 : pre ? 8'd2 : first ? 8'd1 : 8'd0;
        return {ft, g, g, g};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0)      e = 8'd0;
        else if (k == 1) e = 8'hFF;
        else             e = 8'($urandom_range(118, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic push_beat(input logic [31:0] f, input logic first, input logic pre,
                             input logic last, input logic [31:0] exp_word);
        beat_t b;
        b.f = f; b.first = first; b.pre = pre; b.last = last;
        in_q.push_back(b);
        exp_q.push_back(exp_word);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_data_valid = 1'b0;
        in_result_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles mid-stream
    task automatic run_stream(input int mode);
        int n;
        n = in_q.size();
        fork
            begin
                int cyc;
                cyc = 0;
                while (in_q.size() > 0 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    in_data_valid  = 1'b1;
                    in_float_pixel = in_q[0].f;
                    in_first_frame = in_q[0].first;
                    in_pre_last    = in_q[0].pre;
                    in_last_frame  = in_q[0].last;
                    case (mode)
                        1:       in_result_ready = ($urandom_range(0, 3) != 0);
                        2:       in_result_ready = !(cyc >= 3 && cyc < 8);
                        default: in_result_ready = 1'b1;
                    endcase
                    #1;
                    if (ou_data_ready) void'(in_q.pop_front());
                end
                @(negedge clk);
                in_data_valid = 1'b0;
                in_first_frame = 1'b0; in_pre_last = 1'b0; in_last_frame = 1'b0;
                in_result_ready = 1'b1;
            end
            begin
                int          got;
                int          budget;
                logic        stalled;
                logic [31:0] held;
                logic [31:0] exp_w;
                got = 0; budget = 0; stalled = 1'b0; held = 32'd0;
                while (got < n && budget < 3000) begin
                    @(negedge clk);
                    #2;
                    budget++;
                    if (stalled) begin
                        checks++;
                        if (ou_result_valid !== 1'b1 || ou_rgb_pixel !== held) begin
                            errors++;
                            $display("FAIL stall_hold: got valid=%b pixel=%h, required valid=1 pixel=%h",
                                     ou_result_valid, ou_rgb_pixel, held);
                        end
                    end
                    stalled = ou_result_valid && !in_result_ready;
                    held    = ou_rgb_pixel;
                    if (ou_result_valid === 1'b1 && in_result_ready) begin
                        exp_w = exp_q.pop_front();
                        got++;
                        checks++;
                        if (ou_rgb_pixel !== exp_w) begin
                            errors++;
                            $display("FAIL pixel[%0d]: got %h, required %h", got - 1, ou_rgb_pixel, exp_w);
                        end
                    end
                end
                if (got < n) begin
                    errors++;
                    $display("FAIL stream_timeout: got %0d beats, required %0d", got, n);
                end
            end
        join
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (ou_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL extra_beat: got valid=%b pixel=%h, required valid=0", ou_result_valid, ou_rgb_pixel);
        end
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic check_frame(input string name, input logic [COUNT_W-1:0] cnt, input logic err);
        checks++;
        if (ou_frame_pixel_count !== cnt || ou_frame_error !== err) begin
            errors++;
            $display("FAIL %s: got count=%0d error=%b, required count=%0d error=%b",
                     name, ou_frame_pixel_count, ou_frame_error, cnt, err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++;
        if (ou_result_valid !== 1'b0 || ou_rgb_pixel !== 32'd0 || ou_frame_error !== 1'b0 ||
            ou_frame_pixel_count !== '0 || ou_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b pixel=%h err=%b count=%0d ready=%b, required 0,0,0,0,1",
                     ou_result_valid, ou_rgb_pixel, ou_frame_error, ou_frame_pixel_count, ou_data_ready);
        end
    endtask

    task automatic test_first_pixel();
        do_reset();
        @(negedge clk);
        in_data_valid = 1'b1; in_float_pixel = 32'h42C80000; in_first_frame = 1'b1;
        @(negedge clk);
        in_data_valid = 1'b0; in_first_frame = 1'b0;
        #2;
        checks++;
        if (ou_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%b, required 0", ou_result_valid);
        end
        @(negedge clk);
        #2;
        checks++;
        if (ou_result_valid !== 1'b1 || ou_rgb_pixel !== 32'h01646464) begin
            errors++;
            $display("FAIL first_pixel: got valid=%b pixel=%h, required valid=1 pixel=01646464",
                     ou_result_valid, ou_rgb_pixel);
        end
        // The frame opened above must still be open: closing it gives count 3.
        push_beat(32'h40000000, 1'b0, 1'b1, 1'b0, ref_word(32'h40000000, 1'b0, 1'b1, 1'b0));
        push_beat(32'h40400000, 1'b0, 1'b0, 1'b1, ref_word(32'h40400000, 1'b0, 1'b0, 1'b1));
        run_stream(0);
        check_frame("first_frame_close", 20'd3, 1'b0);
    endtask

    task automatic test_conversion();
        do_reset();
        push_beat(32'h437F0000, 1'b0, 1'b0, 1'b0, 32'h00FFFFFF);
        push_beat(32'h43800000, 1'b0, 1'b0, 1'b0, 32'h00FFFFFF);
        push_beat(32'h3F000000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        push_beat(32'h7FC00000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        push_beat(32'h4121999A, 1'b0, 1'b0, 1'b0, 32'h000A0A0A);
        push_beat(32'h3F800000, 1'b0, 1'b0, 1'b0, 32'h00010101);
        push_beat(32'h7F800000, 1'b0, 1'b0, 1'b0, 32'h00FFFFFF);
        push_beat(32'h00400000, 1'b0, 1'b0, 1'b0, 32'h00000000);
`ifdef GRAY_ABS_MAGNITUDE_EN
        push_beat(32'hC2C80000, 1'b0, 1'b0, 1'b0, 32'h00646464);
        push_beat(32'hFF800000, 1'b0, 1'b0, 1'b0, 32'h00FFFFFF);
`else
        push_beat(32'hC2C80000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        push_beat(32'hFF800000, 1'b0, 1'b0, 1'b0, 32'h00000000);
`endif
        push_beat(32'hFFC00000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        run_stream(0);
    endtask

    task automatic test_frame();
        do_reset();
        push_beat(32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h01010101);
        push_beat(32'h40000000, 1'b0, 1'b0, 1'b0, 32'h00020202);
        push_beat(32'h40400000, 1'b0, 1'b0, 1'b0, 32'h00030303);
        push_beat(32'h40800000, 1'b0, 1'b0, 1'b0, 32'h00040404);
        push_beat(32'h40A00000, 1'b0, 1'b1, 1'b0, 32'h02050505);
        push_beat(32'h40C00000, 1'b0, 1'b0, 1'b1, 32'h03060606);
        run_stream(0);
        check_frame("frame6", 20'd6, 1'b0);
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] f;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f = {1'b0, 8'($urandom_range(127, 134)), 23'($urandom)};
            push_beat(f, i == 0, i == 2, i == 3, ref_word(f, i == 0, i == 2, i == 3));
        end
        run_stream(2);
        check_frame("stall_frame", 20'd4, 1'b0);
    endtask

    task automatic test_errors();
        do_reset();
        push_beat(32'h40000000, 1'b0, 1'b0, 1'b0, 32'h00020202);
        run_stream(0);
        check_frame("plain_in_idle", 20'd0, 1'b1);
        // Reset while a beat sits in stage 1: it must never appear.
        @(negedge clk);
        in_data_valid = 1'b1; in_float_pixel = 32'h3F800000; in_first_frame = 1'b1;
        @(negedge clk);
        in_data_valid = 1'b0; in_first_frame = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            checks++;
            if (ou_result_valid !== 1'b0) begin
                errors++;
                $display("FAIL midframe_reset_valid: got %b, required 0", ou_result_valid);
            end
        end
        check_frame("midframe_reset", 20'd0, 1'b0);
        // FSM back in IDLE: a single-pixel frame is legal.
        push_beat(32'h41200000, 1'b1, 1'b0, 1'b1, 32'h030A0A0A);
        run_stream(0);
        check_frame("single_pixel", 20'd1, 1'b0);
        push_beat(32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h01010101);
        push_beat(32'h3F800000, 1'b0, 1'b0, 1'b0, 32'h00010101);
        push_beat(32'h3F800000, 1'b0, 1'b0, 1'b1, 32'h03010101);
        run_stream(0);
        check_frame("last_without_pre", 20'd3, 1'b1);
        do_reset();
        #2;
        check_frame("error_cleared", 20'd0, 1'b0);
    endtask

    task automatic test_random();
        int          len;
        logic [31:0] f;
        do_reset();
        len = 0;
        for (int fr = 0; fr < 12; fr++) begin
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                f = rand_float();
                push_beat(f, i == 0, i == len - 2, i == len - 1,
                          ref_word(f, i == 0, i == len - 2, i == len - 1));
            end
        end
        run_stream(1);
        check_frame("random_frames", COUNT_W'(len), 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_conversion();
        test_frame();
        test_back_to_back_stall();
        test_errors();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
